// File: rtl/pwm_capture.sv
// PWM receiver: measures high time and rise-to-rise period of an asynchronous
// input in clk cycles, with a sticky timeout when the input stops toggling.
module pwm_capture #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT     = 2000000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             pwm_in,
  output logic [WIDTH-1:0] d_meas,
  output logic [WIDTH-1:0] t_meas,
  output logic             valid,
  output logic             timeout,
  output logic             stuck_level
);

  localparam logic [WIDTH-1:0] TIMEOUT_C = WIDTH'(TIMEOUT);
  localparam logic [WIDTH-1:0] ONE_C     = WIDTH'(1);

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic [WIDTH-1:0]       cnt_hi_q, cnt_hi_d;
  logic [WIDTH-1:0]       cnt_per_q, cnt_per_d;
  logic [WIDTH-1:0]       d_meas_q, d_meas_d;
  logic [WIDTH-1:0]       t_meas_q, t_meas_d;
  logic                   valid_q, valid_d;
  logic                   timeout_q, timeout_d;
  logic                   stuck_q, stuck_d;

  logic s, rise, fall;

  assign s    = sync_q[SYNC_STAGES-1];
  assign rise = s & ~prev_q;
  assign fall = ~s & prev_q;

  // The synchroniser and edge history run regardless of enable.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in};
      prev_q <= s;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_hi_q  <= '0;
      cnt_per_q <= '0;
      d_meas_q  <= '0;
      t_meas_q  <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      stuck_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_hi_q  <= cnt_hi_d;
      cnt_per_q <= cnt_per_d;
      d_meas_q  <= d_meas_d;
      t_meas_q  <= t_meas_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
      stuck_q   <= stuck_d;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no latches.
    state_d   = state_q;
    cnt_hi_d  = cnt_hi_q;
    cnt_per_d = cnt_per_q;
    d_meas_d  = d_meas_q;
    t_meas_d  = t_meas_q;
    valid_d   = 1'b0;
    timeout_d = timeout_q;
    stuck_d   = stuck_q;

    if (!enable) begin
      state_d   = IDLE;
      cnt_hi_d  = '0;
      cnt_per_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (rise) begin
            cnt_hi_d  = ONE_C;
            cnt_per_d = ONE_C;
            state_d   = HIGH;
          end
        end
        HIGH: begin
          // Timeout beats a coincident fall so cnt_per never passes TIMEOUT.
          if (cnt_per_q == TIMEOUT_C) begin
            state_d   = IDLE;
            timeout_d = 1'b1;
            stuck_d   = s;
          end else begin
            cnt_per_d = cnt_per_q + ONE_C;
            if (s)    cnt_hi_d = cnt_hi_q + ONE_C;
            if (fall) state_d  = LOW;
          end
        end
        LOW: begin
          if (rise) begin
            d_meas_d  = cnt_hi_q;
            t_meas_d  = cnt_per_q;
            valid_d   = 1'b1;
            timeout_d = 1'b0;
            cnt_hi_d  = ONE_C;
            cnt_per_d = ONE_C;
            state_d   = HIGH;
          end else if (cnt_per_q == TIMEOUT_C) begin
            state_d   = IDLE;
            timeout_d = 1'b1;
            stuck_d   = s;
          end else begin
            cnt_per_d = cnt_per_q + ONE_C;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign d_meas      = d_meas_q;
  assign t_meas      = t_meas_q;
  assign valid       = valid_q;
  assign timeout     = timeout_q;
  assign stuck_level = stuck_q;

endmodule
